my_interface: RTL and testbench
===============================

MY_INTERFACE -- requirements
Module: my_interface

Interface
REQ-001 Parameter: WIDTH, default 32, width of the shared variable and all value ports (two's-complement, int semantics).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0  input  1  client 0 fetch-and-increment request.
REQ-006 req1  input  1  client 1 fetch-and-increment request.
REQ-007 load  input  1  overwrite shared variable with load_val.
REQ-008 load_val  input  WIDTH  value written on load.
REQ-009 ack0 / ack1  output  1 each  registered completion of client 0 / client 1 request.
REQ-010 rdata0 / rdata1  output  WIDTH each  pre-increment value returned to client 0 / client 1.
REQ-011 hello_valid  output  1  one-cycle greeting pulse after reset release.
REQ-012 hello_val  output  WIDTH  value carried by the greeting pulse.
REQ-013 shared_val  output  WIDTH  current shared variable, read-only view.

Function
REQ-014 Shared variable V SHALL be a WIDTH-bit register; every increment SHALL wrap modulo 2^WIDTH (max -> 0, no saturation, no flag).
REQ-015 Greeting: on the first rising clk edge with rst_n high after reset, hello_valid SHALL pulse for exactly one cycle with hello_val = V (0), and V SHALL post-increment by 1 in that same edge.
REQ-016 Greeting SHALL occur once per reset; client requests in the greeting cycle SHALL be serviced after it (V sequence continues from greeting value + 1).
REQ-017 Single request (reqN only): next cycle ackN = 1, rdataN = old V; V <= V + 1.
REQ-018 Simultaneous req0 and req1: both acked same cycle; rdata0 = V, rdata1 = V + 1; V <= V + 2 (client 0 has order priority).
REQ-019 Greeting plus request(s) in same cycle: greeting takes V, then client 0, then client 1 in that order; V advances by total count.
REQ-020 load SHALL have highest priority: V <= load_val; requests in that cycle still acked with rdata computed from old V as per REQ-017/018, but increments discarded.
REQ-021 Latency: ack/rdata/hello registered, 1 cycle after request edge; no backpressure, request accepted every cycle.
REQ-022 ackN SHALL be low in cycles with no request; rdataN SHALL hold last returned value when ackN is low.
REQ-023 shared_val SHALL equal V register directly (reflects updates on the edge after they occur).

Reset
REQ-024 rst_n low SHALL immediately clear V, ack0, ack1, rdata0, rdata1, hello_valid, hello_val to 0 and rearm the greeting.
REQ-025 Reset asserted mid-operation SHALL abort pending acks; no ack or greeting emitted while rst_n low.
REQ-026 Reset deassertion is synchronised internally; greeting fires on the first edge after rst_n is seen high.

Verification
REQ-027 Release reset, no requests -> hello_valid pulses once with hello_val = 0; shared_val = 1 thereafter; no second pulse.
REQ-028 After greeting, req0 for 3 consecutive cycles -> ack0 three cycles, rdata0 = 1, 2, 3; shared_val = 4.
REQ-029 V = 10, req0 and req1 together -> rdata0 = 10, rdata1 = 11, both acks high, shared_val = 12.
REQ-030 load with load_val = 0xFFFFFFFF, then req1 -> rdata1 = 0xFFFFFFFF, shared_val wraps to 0.
REQ-031 load with load_val = 5 plus req0 same cycle with V = 20 -> rdata0 = 20, shared_val = 5.
REQ-032 Assert rst_n low while req0 held high -> outputs 0 immediately; after release, greeting again with hello_val = 0.

Source files
------------

// File: rtl/my_interface_if.sv
// Client/bus bundle for the shared fetch-and-increment counter.
// The slave modport is the counter itself; the master modport is its client side.
interface my_interface_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic             req1;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] rdata0;
  logic [WIDTH-1:0] rdata1;
  logic             hello_valid;
  logic [WIDTH-1:0] hello_val;
  logic [WIDTH-1:0] shared_val;

  modport master (
    output req0, req1, load, load_val,
    input  ack0, ack1, rdata0, rdata1, hello_valid, hello_val, shared_val
  );

  modport slave (
    input  req0, req1, load, load_val,
    output ack0, ack1, rdata0, rdata1, hello_valid, hello_val, shared_val
  );
endinterface

// File: rtl/my_interface.sv
// Shared wrapping counter serving two fetch-and-increment clients plus a
// one-shot greeting that claims the first value after every reset.
module my_interface #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  my_interface_if.slave bus
);

  logic [WIDTH-1:0] v_reg;
  logic [WIDTH-1:0] v_next;
  logic             greet_pending_reg;
  logic             hello_valid_reg;
  logic [WIDTH-1:0] hello_val_reg;
  logic [1:0]       req_vec;
  logic [WIDTH-1:0] greet_inc;

  assign req_vec   = {bus.req1, bus.req0};
  assign greet_inc = WIDTH'(greet_pending_reg);

  // Order within a cycle: greeting first, then client 0, then client 1.
  always_comb begin
    v_next = v_reg + greet_inc + WIDTH'($countones(req_vec));
    if (bus.load) begin
      v_next = bus.load_val;
    end
  end

  // Armed by reset, so the greeting fires on the first edge that sees rst_n high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg             <= '0;
      greet_pending_reg <= 1'b1;
      hello_valid_reg   <= 1'b0;
      hello_val_reg     <= '0;
    end else begin
      v_reg             <= v_next;
      greet_pending_reg <= 1'b0;
      hello_valid_reg   <= greet_pending_reg;
      if (greet_pending_reg) begin
        hello_val_reg <= v_reg;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : client
    // Mask of the lower-numbered clients that take a value ahead of this one.
    localparam logic [1:0] AHEAD_MASK = 2'((1 << gi) - 1);

    logic [WIDTH-1:0] slot_val;
    logic             ack_reg;
    logic [WIDTH-1:0] rdata_reg;

    assign slot_val = v_reg + greet_inc + WIDTH'($countones(req_vec & AHEAD_MASK));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ack_reg   <= 1'b0;
        rdata_reg <= '0;
      end else begin
        ack_reg <= req_vec[gi];
        if (req_vec[gi]) begin
          rdata_reg <= slot_val;
        end
      end
    end
  end

  assign bus.ack0        = client[0].ack_reg;
  assign bus.ack1        = client[1].ack_reg;
  assign bus.rdata0      = client[0].rdata_reg;
  assign bus.rdata1      = client[1].rdata_reg;
  assign bus.hello_valid = hello_valid_reg;
  assign bus.hello_val   = hello_val_reg;
  assign bus.shared_val  = v_reg;

endmodule

// File: tb/tb_my_interface.sv
// Self-checking bench for my_interface: a reference model pushes the expected
// output bundle per driven cycle, and each scenario pops and compares it.
module tb_my_interface;

  localparam int W  = 32;
  localparam int VW = 3 + 4 * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  my_interface_if #(.WIDTH(W)) bus ();

  my_interface #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  wire [VW-1:0] obs = {bus.ack0, bus.ack1, bus.hello_valid,
                       bus.rdata0, bus.rdata1, bus.hello_val, bus.shared_val};

  logic [VW-1:0] sb [$];
  logic [VW-1:0] exp_v;

  logic [W-1:0] m_v, m_rd0, m_rd1, m_hv;
  logic         m_greet;

  task automatic model_reset();
    m_v = '0; m_rd0 = '0; m_rd1 = '0; m_hv = '0; m_greet = 1'b1;
    sb.delete();
  endtask

  // Drive one cycle of stimulus, push the expected result, and land 1 time unit after the edge.
  task automatic step(input logic r0, input logic r1, input logic ld, input logic [W-1:0] lv);
    logic [W-1:0] s0, s1;
    logic         g;
    @(negedge clk);
    bus.req0 = r0; bus.req1 = r1; bus.load = ld; bus.load_val = lv;
    g  = m_greet;
    if (g) m_hv = m_v;
    s0 = m_v + W'(g);
    s1 = s0 + W'(r0);
    if (r0) m_rd0 = s0;
    if (r1) m_rd1 = s1;
    m_v = ld ? lv : (s1 + W'(r1));
    m_greet = 1'b0;
    sb.push_back({r0, r1, g, m_rd0, m_rd1, m_hv, m_v});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", obs);
    end
    #1 rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_greeting();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL greeting[%0d] got=%h want=%h", i, obs, exp_v);
      end
      $display("greeting cycle %0d hello_valid=%0b hello_val=%0d shared=%0d",
               i, bus.hello_valid, bus.hello_val, bus.shared_val);
      checks++;
      if (bus.hello_valid !== (i == 0) || bus.hello_val !== 32'd0 || bus.shared_val !== 32'd1) begin
        failures++;
        $display("FAIL greeting_fixed[%0d] hv=%0b hval=%0d shared=%0d want %0b/0/1",
                 i, bus.hello_valid, bus.hello_val, bus.shared_val, i == 0);
      end
    end
  endtask

  task automatic test_req0_burst();
    for (int i = 0; i < 4; i++) begin
      step(i < 3, 1'b0, 1'b0, '0);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL req0_burst[%0d] got=%h want=%h", i, obs, exp_v);
      end
      $display("req0_burst %0d ack0=%0b rdata0=%0d shared=%0d", i, bus.ack0, bus.rdata0, bus.shared_val);
      checks++;
      if (bus.ack0 !== (i < 3) || bus.rdata0 !== W'((i < 3) ? i + 1 : 3)) begin
        failures++;
        $display("FAIL req0_fixed[%0d] ack0=%0b rdata0=%0d", i, bus.ack0, bus.rdata0);
      end
    end
    checks++;
    if (bus.shared_val !== 32'd4) begin
      failures++;
      $display("FAIL req0_shared got=%0d want=4", bus.shared_val);
    end
  endtask

  task automatic test_dual();
    step(1'b0, 1'b0, 1'b1, 32'd10);
    step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 2; i++) begin
      exp_v = sb.pop_front();
      if (i == 1) begin
        checks++;
        if (obs !== exp_v) begin
          failures++;
          $display("FAIL dual got=%h want=%h", obs, exp_v);
        end
      end
    end
    $display("dual rdata0=%0d rdata1=%0d shared=%0d", bus.rdata0, bus.rdata1, bus.shared_val);
    checks++;
    if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b1 || bus.rdata0 !== 32'd10 ||
        bus.rdata1 !== 32'd11 || bus.shared_val !== 32'd12) begin
      failures++;
      $display("FAIL dual_fixed acks=%0b%0b rd0=%0d rd1=%0d shared=%0d want 11/10/11/12",
               bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, bus.shared_val);
    end
  endtask

  task automatic test_load_wrap();
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v || bus.shared_val !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL load_max got=%h want=%h", obs, exp_v);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    exp_v = sb.pop_front();
    $display("wrap rdata1=%h shared=%0d", bus.rdata1, bus.shared_val);
    checks++;
    if (obs !== exp_v || bus.rdata1 !== 32'hFFFF_FFFF || bus.shared_val !== 32'd0) begin
      failures++;
      $display("FAIL wrap rd1=%h shared=%0d got=%h want=%h", bus.rdata1, bus.shared_val, obs, exp_v);
    end
  endtask

  task automatic test_load_with_req();
    step(1'b0, 1'b0, 1'b1, 32'd20);
    void'(sb.pop_front());
    step(1'b1, 1'b0, 1'b1, 32'd5);
    exp_v = sb.pop_front();
    $display("load+req0 ack0=%0b rdata0=%0d shared=%0d", bus.ack0, bus.rdata0, bus.shared_val);
    checks++;
    if (obs !== exp_v || bus.ack0 !== 1'b1 || bus.rdata0 !== 32'd20 || bus.shared_val !== 32'd5) begin
      failures++;
      $display("FAIL load_req rd0=%0d shared=%0d want 20/5 got=%h want=%h",
               bus.rdata0, bus.shared_val, obs, exp_v);
    end
  endtask

  task automatic test_random();
    logic r0, r1, ld;
    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 7) == 0);
      step(r0, r1, ld, W'($urandom));
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL random[%0d] got=%h want=%h", i, obs, exp_v);
      end
      $display("random %0d req=%0b%0b load=%0b rd0=%0d rd1=%0d shared=%0d",
               i, r0, r1, ld, bus.rdata0, bus.rdata1, bus.shared_val);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b0, '0);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v || bus.ack0 !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got=%h want=%h", obs, exp_v);
    end
    // Assert reset between edges with req0 still high: outputs must clear at once.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_async got=%h want=0", obs);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_hold got=%h want=0", obs);
    end
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0);
    exp_v = sb.pop_front();
    $display("post-reset hello_valid=%0b hello_val=%0d rdata0=%0d shared=%0d",
             bus.hello_valid, bus.hello_val, bus.rdata0, bus.shared_val);
    checks++;
    if (obs !== exp_v || bus.hello_valid !== 1'b1 || bus.hello_val !== 32'd0 ||
        bus.rdata0 !== 32'd1 || bus.shared_val !== 32'd2) begin
      failures++;
      $display("FAIL regreet hv=%0b hval=%0d rd0=%0d shared=%0d want 1/0/1/2",
               bus.hello_valid, bus.hello_val, bus.rdata0, bus.shared_val);
    end
    step(1'b0, 1'b0, 1'b0, '0);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL regreet_once got=%h want=%h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_greeting();
    test_req0_burst();
    test_dual();
    test_load_wrap();
    test_load_with_req();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
